// File: rtl/bcd_seq_converter_if.sv
// Start/result handshake between a binary result producer and the BCD converter.
// The producer drives start/binary_in; the converter returns status and packed BCD.
interface bcd_seq_converter_if #(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 10
);
   logic                  start;
   logic [WIDTH-1:0]      binary_in;
   logic                  ready;
   logic                  busy;
   logic                  done;
   logic [DIGITS*4-1:0]   bcd_out;
   logic [3:0]            bcd_ones;

   modport master (
      output start,
      output binary_in,
      input  ready,
      input  busy,
      input  done,
      input  bcd_out,
      input  bcd_ones
   );

   modport slave (
      input  start,
      input  binary_in,
      output ready,
      output busy,
      output done,
      output bcd_out,
      output bcd_ones
   );
endinterface

// File: rtl/bcd_seq_converter.sv
// Sequential double-dabble binary-to-BCD converter: one shift per clock, WIDTH clocks
// per conversion, result held in bcd_out until the next conversion completes.
module bcd_seq_converter #(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   bcd_seq_converter_if.slave bus
);
   localparam int              SW   = DIGITS * 4;
   localparam int              CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t            state_q;
   logic [WIDTH-1:0]  shift_q;
   logic [WIDTH-1:0]  shift_d;
   logic [SW-1:0]     scratch_q;
   logic [SW-1:0]     scratch_d;
   logic [SW-1:0]     scratch_adj;
   logic [CW-1:0]     cnt_q;
   logic [SW-1:0]     bcd_q;
   logic              done_q;
   logic              busy_q;
   logic              ready_q;

   function automatic logic [SW-1:0] adjust_digits(input logic [SW-1:0] s);
      logic [SW-1:0] r;
      r = s;
      for (int i = 0; i < DIGITS; i++) begin
         if (s[i*4 +: 4] >= 4'd5) begin
            r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
         end else begin
            r[i*4 +: 4] = s[i*4 +: 4];
         end
      end
      return r;
   endfunction

   // Add-3 correction followed by a one-bit left shift of {scratch, shift}.
   always_comb begin
      scratch_adj = adjust_digits(scratch_q);
      scratch_d   = SW'({scratch_adj, shift_q[WIDTH-1]});
      shift_d     = {shift_q[WIDTH-2:0], 1'b0};
   end

   // Control FSM with registered status outputs and the held result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         bcd_q     <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  state_q   <= ST_SHIFT;
                  shift_q   <= bus.binary_in;
                  scratch_q <= '0;
                  cnt_q     <= '0;
                  busy_q    <= 1'b1;
                  ready_q   <= 1'b0;
               end else begin
                  state_q   <= ST_IDLE;
                  busy_q    <= 1'b0;
                  ready_q   <= 1'b1;
               end
            end
            ST_SHIFT: begin
               shift_q   <= shift_d;
               scratch_q <= scratch_d;
               if (cnt_q == LAST) begin
                  // Counter parks at LAST; it is cleared again on the next accept.
                  bcd_q   <= scratch_d;
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
               end else begin
                  cnt_q   <= cnt_q + CW'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.ready    = ready_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.bcd_out  = bcd_q;
   assign bus.bcd_ones = bcd_q[3:0];

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed bench for bcd_seq_converter: latency, held result, ignored starts,
// back-to-back accepts and mid-conversion reset, all against hand-computed BCD.
module tb_bcd_seq_converter;
   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_total;
   int   cycle_cnt;
   logic [39:0] exp_prev;

   bcd_seq_converter_if #(.WIDTH(32), .DIGITS(10)) bus ();

   bcd_seq_converter #(.WIDTH(32), .DIGITS(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One conversion; optionally re-assert start with 99 at busy cycle inject_at.
   task automatic run_conv(input string tag, input logic [31:0] val,
                           input logic [39:0] exp_bcd, input int inject_at);
      int   cyc;
      int   busy_cnt;
      bit   hold_bad;
      @(negedge clk);
      check_eq({tag, "_ready"}, {63'd0, bus.ready}, 64'd1);
      bus.start     = 1'b1;
      bus.binary_in = val;
      @(negedge clk);
      bus.start     = 1'b0;
      bus.binary_in = ~val;
      cyc      = 0;
      busy_cnt = 0;
      hold_bad = 1'b0;
      while (bus.done !== 1'b1 && cyc < 100) begin
         if (bus.busy === 1'b1) busy_cnt++;
         if (bus.bcd_out !== exp_prev) hold_bad = 1'b1;
         if (cyc == inject_at) begin
            bus.start     = 1'b1;
            bus.binary_in = 32'd99;
         end else begin
            bus.start     = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      bus.start = 1'b0;
      check_eq({tag, "_latency"}, 64'(cyc), 64'd32);
      check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
      check_eq({tag, "_held_during_shift"}, {63'd0, hold_bad}, 64'd0);
      check_eq({tag, "_bcd_out"}, {24'd0, bus.bcd_out}, {24'd0, exp_bcd});
      check_eq({tag, "_bcd_ones"}, {60'd0, bus.bcd_ones}, {60'd0, exp_bcd[3:0]});
      @(negedge clk);
      check_eq({tag, "_done_one_cycle"}, {63'd0, bus.done}, 64'd0);
      check_eq({tag, "_bcd_after"}, {24'd0, bus.bcd_out}, {24'd0, exp_bcd});
      exp_prev = exp_bcd;
   endtask

   initial begin
      int cyc;
      int t1;
      int t2;
      bit seen_done;
      n_pass        = 0;
      n_total       = 0;
      cycle_cnt     = 0;
      exp_prev      = 40'd0;
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.binary_in = 32'd0;
      repeat (2) @(negedge clk);
      check_eq("rst_ready", {63'd0, bus.ready}, 64'd1);
      check_eq("rst_busy", {63'd0, bus.busy}, 64'd0);
      check_eq("rst_done", {63'd0, bus.done}, 64'd0);
      check_eq("rst_bcd", {24'd0, bus.bcd_out}, 64'd0);
      rst_n = 1'b1;

      run_conv("zero",  32'd0,          40'h00_0000_0000, -1);
      run_conv("v1234", 32'd1234,       40'h00_0000_1234, -1);
      run_conv("max",   32'hFFFF_FFFF,  40'h42_9496_7295, -1);
      run_conv("v9",    32'd9,          40'h00_0000_0009, -1);
      run_conv("v10",   32'd10,         40'h00_0000_0010, -1);
      run_conv("v99999",32'd99999,      40'h00_0009_9999, -1);
      run_conv("busy7", 32'd7,          40'h00_0000_0007, 10);
      check_eq("busy7_idle_ready", {63'd0, bus.ready}, 64'd1);

      // Back-to-back: start held, second value presented in the DONE cycle.
      @(negedge clk);
      bus.start     = 1'b1;
      bus.binary_in = 32'd58;
      @(negedge clk);
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < 100) begin
         check_eq("b2b_held7", {24'd0, bus.bcd_out}, 64'h7);
         @(negedge clk);
         cyc++;
      end
      t1 = cycle_cnt;
      check_eq("b2b_lat1", 64'(cyc), 64'd32);
      check_eq("b2b_bcd58", {24'd0, bus.bcd_out}, 64'h58);
      bus.binary_in = 32'd905;
      @(negedge clk);
      bus.start = 1'b0;
      check_eq("b2b_done_pulse1", {63'd0, bus.done}, 64'd0);
      check_eq("b2b_reaccept_busy", {63'd0, bus.busy}, 64'd1);
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      t2 = cycle_cnt;
      check_eq("b2b_spacing", 64'(t2 - t1), 64'd33);
      check_eq("b2b_bcd905", {24'd0, bus.bcd_out}, 64'h905);
      @(negedge clk);
      check_eq("b2b_done_pulse2", {63'd0, bus.done}, 64'd0);

      // Reset in the middle of a conversion.
      bus.start     = 1'b1;
      bus.binary_in = 32'd4321;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (15) @(negedge clk);
      check_eq("abort_busy_before", {63'd0, bus.busy}, 64'd1);
      rst_n = 1'b0;
      #1;
      check_eq("abort_bcd", {24'd0, bus.bcd_out}, 64'd0);
      check_eq("abort_busy", {63'd0, bus.busy}, 64'd0);
      check_eq("abort_done", {63'd0, bus.done}, 64'd0);
      check_eq("abort_ready", {63'd0, bus.ready}, 64'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen_done = 1'b1;
      end
      check_eq("abort_no_done", {63'd0, seen_done}, 64'd0);
      check_eq("abort_ready_after", {63'd0, bus.ready}, 64'd1);
      exp_prev = 40'd0;
      run_conv("v4321", 32'd4321, 40'h00_0000_4321, -1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
